// File: rtl/weight_stream_writer.sv
// rtl/weight_stream_writer.sv - packetised 16-bit word stream to PE weight-write strobes
module weight_stream_writer #(
    parameter int WR_GAP      = 0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [15:0]            weight_wr_data,
    output logic [31:0]            weight_wr_addr,
    output logic                   weight_wr_en,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [COUNT_WIDTH-1:0] pkt_words
);

    localparam int GAP_W = (WR_GAP < 1) ? 1 : $clog2(WR_GAP + 1);

    typedef enum logic [2:0] {
        HDR_HI  = 3'd0,
        HDR_LO  = 3'd1,
        CNT     = 3'd2,
        DATA    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [31:0]            base_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] idx_q;
    logic [COUNT_WIDTH-1:0] cnt_in;
    logic                   accept;
    logic                   wr_d, done_d, err_d, ready_d, busy_d;

    // Next-state decode: framing checks, gap reload/countdown and next registered outputs
    always_comb begin
        state_d = state_q;
        accept  = s_valid && s_ready;
        cnt_in  = COUNT_WIDTH'(s_data);
        gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    if (s_last) err_d = 1'b1;
                    else        state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if (s_last) begin
                        err_d   = 1'b1;
                        state_d = HDR_HI;
                    end else begin
                        state_d = CNT;
                    end
                end
            end
            CNT: begin
                if (accept) begin
                    if (cnt_in == '0) begin
                        if (s_last) begin
                            done_d  = 1'b1;
                            state_d = HDR_HI;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = HDR_HI;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wr_d  = 1'b1;
                    gap_d = GAP_W'(WR_GAP);
                    if (idx_q == cnt_q - COUNT_WIDTH'(1)) begin
                        if (s_last) begin
                            done_d  = 1'b1;
                            state_d = HDR_HI;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = HDR_HI;
                    end
                end
            end
            DISCARD: begin
                if (accept && s_last) begin
                    err_d   = 1'b1;
                    state_d = HDR_HI;
                end
            end
            default: state_d = HDR_HI;
        endcase
        // Only data beats are throttled; headers may arrive during a running gap.
        ready_d = (state_d == DATA) ? (gap_d == '0) : 1'b1;
        busy_d  = (state_d != HDR_HI) || wr_d;
    end

    // State, packet context and registered output updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HDR_HI;
            gap_q          <= '0;
            base_q         <= '0;
            cnt_q          <= '0;
            idx_q          <= '0;
            s_ready        <= 1'b0;
            weight_wr_en   <= 1'b0;
            weight_wr_addr <= '0;
            weight_wr_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            pkt_words      <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            s_ready      <= ready_d;
            weight_wr_en <= wr_d;
            done         <= done_d;
            err          <= err_d;
            busy         <= busy_d;
            if (accept) begin
                case (state_q)
                    HDR_HI:  if (!s_last) base_q[31:16] <= s_data;
                    HDR_LO:  base_q[15:0] <= s_data;
                    CNT: begin
                        cnt_q     <= cnt_in;
                        idx_q     <= '0;
                        pkt_words <= '0;
                    end
                    DATA: begin
                        weight_wr_addr <= base_q + 32'(idx_q);
                        weight_wr_data <= s_data;
                        idx_q          <= idx_q + COUNT_WIDTH'(1);
                        pkt_words      <= pkt_words + COUNT_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
